// File: rtl/iomem_fabric.sv
// iomem_fabric: picosoc iomem bus fabric; decodes addr[31:24] to one of
// NUM_SLAVES peripherals, adds bus timeout and unmapped-address errors.
// Ports: clk/reset; m_* master side (valid/wstrb/addr/wdata in,
// ready/rdata out); s_* slave side (one-hot valid, shared wstrb/addr/wdata
// out, per-slave ready/rdata in); err_irq/err_addr/err_count status out.
module iomem_fabric #(
  parameter int                      NUM_SLAVES     = 4,
  parameter logic [8*NUM_SLAVES-1:0] SLAVE_BASES    = 32'h07050403,
  parameter int                      TIMEOUT_CYCLES = 255,
  parameter logic [31:0]             ERR_RDATA      = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m_valid,
  input  logic [3:0]               m_wstrb,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  output logic                     m_ready,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic [3:0]               s_wstrb,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic                     err_irq,
  output logic [31:0]              err_addr,
  output logic [7:0]               err_count
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] s_valid_q, s_valid_d;
  logic [3:0]            s_wstrb_q, s_wstrb_d;
  logic [31:0]           s_addr_q, s_addr_d;
  logic [31:0]           s_wdata_q, s_wdata_d;
  logic                  m_ready_q, m_ready_d;
  logic [31:0]           m_rdata_q, m_rdata_d;
  logic                  err_irq_q, err_irq_d;
  logic [31:0]           err_addr_q, err_addr_d;
  logic [7:0]            err_count_q, err_count_d;

  logic          hit;
  logic [SW-1:0] hit_idx;
  logic          err_set;
  logic [31:0]   err_src;

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (m_addr[31:24] == SLAVE_BASES[8*i +: 8]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    s_valid_d   = '0;
    s_wstrb_d   = s_wstrb_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    m_ready_d   = 1'b0;
    m_rdata_d   = m_rdata_q;
    err_irq_d   = 1'b0;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    err_set     = 1'b0;
    err_src     = s_addr_q;
    unique case (state_q)
      IDLE: begin
        if (m_valid) begin
          s_wstrb_d = m_wstrb;
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          if (hit) begin
            sel_d     = hit_idx;
            cnt_d     = '0;
            s_valid_d = NUM_SLAVES'(1) << hit_idx;
            state_d   = ACCESS;
          end else begin
            err_set = 1'b1;
            err_src = m_addr;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        // Ready wins over a timeout landing in the same cycle.
        if (s_ready[sel_q]) begin
          m_ready_d = 1'b1;
          m_rdata_d = s_rdata[{sel_q, 5'b0} +: 32];
          state_d   = RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_set = 1'b1;
          state_d = RESP;
        end else if (!m_valid) begin
          state_d = IDLE;
        end else begin
          cnt_d     = cnt_q + CW'(1);
          s_valid_d = s_valid_q;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (err_set) begin
      m_ready_d  = 1'b1;
      m_rdata_d  = ERR_RDATA;
      err_irq_d  = 1'b1;
      err_addr_d = err_src;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      s_valid_q   <= '0;
      s_wstrb_q   <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      m_ready_q   <= 1'b0;
      m_rdata_q   <= '0;
      err_irq_q   <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      s_valid_q   <= s_valid_d;
      s_wstrb_q   <= s_wstrb_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      m_ready_q   <= m_ready_d;
      m_rdata_q   <= m_rdata_d;
      err_irq_q   <= err_irq_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign m_ready   = m_ready_q;
  assign m_rdata   = m_rdata_q;
  assign s_valid   = s_valid_q;
  assign s_wstrb   = s_wstrb_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign err_irq   = err_irq_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_iomem_fabric.sv
// tb_iomem_fabric: directed plus randomized transactions against a
// cycle-count reference model of the iomem fabric.
module tb_iomem_fabric;

  localparam int T = 8;
  localparam logic [31:0] BASES = 32'h07050403;

  logic         clk = 1'b0;
  logic         reset;
  logic         m_valid;
  logic [3:0]   m_wstrb;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic [3:0]   s_wstrb;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic         err_irq;
  logic [31:0]  err_addr;
  logic [7:0]   err_count;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  logic [31:0] eaddr = '0;

  iomem_fabric #(
    .NUM_SLAVES(4), .SLAVE_BASES(BASES),
    .TIMEOUT_CYCLES(T), .ERR_RDATA(32'h0)
  ) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata),
    .err_irq(err_irq), .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a[31:24] == BASES[8*i +: 8]) return i;
    return -1;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_m_ready", {31'b0, m_ready}, 32'h0);
    chk("rst_s_valid", {28'b0, s_valid}, 32'h0);
    chk("rst_err_irq", {31'b0, err_irq}, 32'h0);
    chk("rst_m_rdata", m_rdata, 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_s_wdata", s_wdata, 32'h0);
    chk("rst_s_wstrb", {28'b0, s_wstrb}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_err_count", {24'b0, err_count}, 32'h0);
  endtask

  // One master transaction; the slave answers after 'waits' wait states.
  // Expected cycle positions follow from the latency rules: miss answers
  // in cycle 1, hit in cycle waits+2, timeout after T cycles of s_valid.
  task automatic txn(input logic [31:0] a, input logic [3:0] ws,
                     input logic [31:0] wd, input int waits);
    int sel, rk;
    bit hit, err;
    logic [31:0] rd;
    logic [3:0] noise, exp_sv;
    sel = decode(a);
    hit = (sel >= 0);
    rd  = $urandom;
    if (!hit) begin rk = 1; err = 1; end
    else if (waits < T) begin rk = waits + 2; err = 0; end
    else begin rk = T + 1; err = 1; end
    @(negedge clk);
    m_valid = 1'b1; m_addr = a; m_wstrb = ws; m_wdata = wd;
    s_ready = '0;
    for (int k = 1; k <= rk; k++) begin
      @(negedge clk);
      exp_sv = (hit && k < rk) ? 4'(1 << sel) : 4'h0;
      chk("s_valid", {28'b0, s_valid}, {28'b0, exp_sv});
      chk("m_ready", {31'b0, m_ready}, {31'b0, k == rk});
      if (k == 1) begin
        chk("s_addr", s_addr, a);
        chk("s_wdata", s_wdata, wd);
        chk("s_wstrb", {28'b0, s_wstrb}, {28'b0, ws});
      end
      if (k == rk) begin
        if (err) begin
          ecnt  = (ecnt < 255) ? ecnt + 1 : 255;
          eaddr = a;
        end
        chk("m_rdata", m_rdata, err ? 32'h0 : rd);
        chk("err_irq", {31'b0, err_irq}, {31'b0, err});
        chk("err_addr", err_addr, eaddr);
        chk("err_count", {24'b0, err_count}, 32'(ecnt));
        m_valid = 1'b0;
      end
      for (int i = 0; i < 4; i++) s_rdata[32*i +: 32] = $urandom;
      noise = 4'($urandom);
      if (hit) begin
        noise[sel] = 1'b0;
        s_rdata[32*sel +: 32] = rd;
        if (k == waits + 1) noise[sel] = 1'b1;
      end
      s_ready = noise;
    end
    s_ready = '0;
  endtask

  initial begin
    reset = 1'b1; m_valid = 1'b0; m_wstrb = '0;
    m_addr = '0; m_wdata = '0; s_ready = '0; s_rdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;

    txn(32'h0300_0004, 4'h0, 32'h0, 0);
    txn(32'h0500_0010, 4'hF, 32'hA5A5_A5A5, 3);
    txn(32'h0600_0000, 4'h0, 32'h0, 0);
    txn(32'h0700_0000, 4'h0, 32'h0, 1000);
    txn(32'h0700_0000, 4'h0, 32'h0, T - 1);
    txn(32'h0400_0100, 4'h3, 32'h1122_3344, T - 2);

    // Master abort mid-access.
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h0300_0008; m_wstrb = 4'h0;
    @(negedge clk);
    chk("abort_s_valid1", {28'b0, s_valid}, 32'h1);
    m_valid = 1'b0;
    @(negedge clk);
    chk("abort_s_valid2", {28'b0, s_valid}, 32'h0);
    chk("abort_m_ready", {31'b0, m_ready}, 32'h0);
    @(negedge clk);
    chk("abort_m_ready2", {31'b0, m_ready}, 32'h0);
    chk("abort_err_count", {24'b0, err_count}, 32'(ecnt));

    for (int n = 0; n < 300; n++)
      txn({8'h06, 24'($urandom)}, 4'h0, 32'h0, 0);
    chk("sat_err_count", {24'b0, err_count}, 32'd255);

    for (int n = 0; n < 150; n++) begin
      logic [7:0] b;
      case ($urandom_range(0, 5))
        0: b = 8'h03;
        1: b = 8'h04;
        2: b = 8'h05;
        3: b = 8'h07;
        4: b = 8'h06;
        default: b = 8'($urandom);
      endcase
      txn({b, 24'($urandom)}, 4'($urandom), $urandom,
          int'($urandom_range(0, 11)));
    end

    // Reset in the middle of an access.
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h0400_0020; m_wstrb = 4'h0;
    @(negedge clk);
    chk("rstmid_s_valid", {28'b0, s_valid}, 32'h2);
    @(negedge clk);
    reset = 1'b1; m_valid = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    ecnt = 0; eaddr = '0;
    txn(32'h0500_0040, 4'hF, 32'hDEAD_BEEF, 1);
    txn(32'h0300_0000, 4'h0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
